// File: rtl/i2s_frame_sched.sv
// Two-source stereo frame scheduler feeding a 16-bit I2S transmitter's parallel input.
// Optional macro I2S_FRAME_SCHED_MIX_EN adds mode 2: saturating mix of both sources.
`timescale 1ns/1ps
module i2s_frame_sched #(
    parameter int W             = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int UNDERRUN_HOLD = 0
) (
    input  logic           CLK,
    input  logic           RST_n,
    input  logic           en,
`ifdef I2S_FRAME_SCHED_MIX_EN
    input  logic [1:0]     mode,
`else
    input  logic           mode,
`endif
    input  logic           src0_valid,
    output logic           src0_ready,
    input  logic [2*W-1:0] src0_data,
    input  logic           src1_valid,
    output logic           src1_ready,
    input  logic [2*W-1:0] src1_data,
    input  logic           i2s_lrck,
    input  logic           i2s_data_clk,
    output logic [W-1:0]   tx_data,
    output logic [1:0]     grant,
    output logic [15:0]    underrun_cnt
);

    typedef enum logic [1:0] {WAIT_WIN, ARB, DRIVE_L, DRIVE_R} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] lrck_sync_q, dclk_sync_q;
    logic                   dclk_prev_q, live_q;
    logic [2*W-1:0]         buf0_q, buf1_q;
    logic                   full0_q, full1_q;
    logic                   rr_q, rr_d;
    logic [2*W-1:0]         active_q, active_d, last_q, last_d;
    logic [W-1:0]           tx_q, tx_d;
    logic [1:0]             grant_q, grant_d;
    logic [15:0]            ur_q, ur_d;

    logic lrck_s, win_start, rr_mode, g0, g1, pop0, pop1;
    logic [2*W-1:0] pick;

    assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
    assign win_start = dclk_sync_q[SYNC_STAGES-1] & ~dclk_prev_q;

    // live_q keeps ready low while reset is asserted and for the first cycle after
    assign src0_ready   = en & live_q & ~full0_q;
    assign src1_ready   = en & live_q & ~full1_q;
    assign tx_data      = tx_q;
    assign grant        = grant_q;
    assign underrun_cnt = ur_q;

`ifdef I2S_FRAME_SCHED_MIX_EN
    logic mix_mode;
    assign rr_mode  = (mode == 2'd1);
    assign mix_mode = (mode == 2'd2);

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1])
            return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return s[W-1:0];
    endfunction
`else
    assign rr_mode = mode;
`endif

    // rr_q = 0 means src0 is looked at first
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (rr_mode && rr_q) begin
            g1 = full1_q;
            g0 = full0_q & ~full1_q;
        end else begin
            g0 = full0_q;
            g1 = full1_q & ~full0_q;
        end
`ifdef I2S_FRAME_SCHED_MIX_EN
        if (mix_mode && full0_q && full1_q) begin
            g0 = 1'b1;
            g1 = 1'b1;
        end
`endif
    end

    always_comb begin
`ifdef I2S_FRAME_SCHED_MIX_EN
        if (g0 && g1)
            pick = {sat_add(buf0_q[2*W-1:W], buf1_q[2*W-1:W]),
                    sat_add(buf0_q[W-1:0],   buf1_q[W-1:0])};
        else
            pick = g0 ? buf0_q : buf1_q;
`else
        pick = g0 ? buf0_q : buf1_q;
`endif
    end

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        grant_d  = grant_q;
        ur_d     = ur_q;
        active_d = en ? active_q : '0;
        last_d   = last_q;
        rr_d     = rr_q;
        pop0     = 1'b0;
        pop1     = 1'b0;
        case (state_q)
            WAIT_WIN: begin
                if (win_start) begin
                    if (!en) begin
                        tx_d    = '0;
                        grant_d = 2'b00;
                    end else if (lrck_s) begin
                        state_d = ARB;
                    end else begin
                        state_d = DRIVE_R;
                    end
                end
            end
            ARB: begin
                state_d = DRIVE_L;
                if (!en) begin
                    tx_d    = '0;
                    grant_d = 2'b00;
                    state_d = WAIT_WIN;
                end else if (g0 || g1) begin
                    pop0     = g0;
                    pop1     = g1;
                    grant_d  = {g1, g0};
                    active_d = pick;
                    last_d   = pick;
                    if (rr_mode) rr_d = g0;
                end else begin
                    ur_d     = (ur_q == 16'hFFFF) ? ur_q : ur_q + 16'd1;
                    grant_d  = 2'b00;
                    active_d = (UNDERRUN_HOLD != 0) ? last_q : '0;
                end
            end
            DRIVE_L: begin
                tx_d    = en ? active_q[2*W-1:W] : '0;
                state_d = WAIT_WIN;
            end
            DRIVE_R: begin
                tx_d    = en ? active_q[W-1:0] : '0;
                state_d = WAIT_WIN;
            end
            default: state_d = WAIT_WIN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= WAIT_WIN;
            lrck_sync_q <= '1;
            dclk_sync_q <= '0;
            dclk_prev_q <= 1'b0;
            live_q      <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            full0_q     <= 1'b0;
            full1_q     <= 1'b0;
            rr_q        <= 1'b0;
            active_q    <= '0;
            last_q      <= '0;
            tx_q        <= '0;
            grant_q     <= 2'b00;
            ur_q        <= '0;
        end else begin
            state_q     <= state_d;
            lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], i2s_lrck};
            dclk_sync_q <= {dclk_sync_q[SYNC_STAGES-2:0], i2s_data_clk};
            dclk_prev_q <= dclk_sync_q[SYNC_STAGES-1];
            live_q      <= 1'b1;
            rr_q        <= rr_d;
            active_q    <= active_d;
            last_q      <= last_d;
            tx_q        <= tx_d;
            grant_q     <= grant_d;
            ur_q        <= ur_d;
            // ready is low while full, so a pop and a refill never share a cycle
            if (src0_valid && src0_ready) begin
                buf0_q  <= src0_data;
                full0_q <= 1'b1;
            end else if (pop0) begin
                full0_q <= 1'b0;
            end
            if (src1_valid && src1_ready) begin
                buf1_q  <= src1_data;
                full1_q <= 1'b1;
            end else if (pop1) begin
                full1_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_frame_sched.sv
// Self-checking bench for i2s_frame_sched: two instances (zero-fill and hold-last underrun)
// driven in parallel and compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_i2s_frame_sched;
    localparam int W = 16;
    localparam int S = 2;
`ifdef I2S_FRAME_SCHED_MIX_EN
    localparam int MW = 2;
`else
    localparam int MW = 1;
`endif

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic          en = 1'b0;
    logic [MW-1:0] mode = '0;
    logic          s0_valid = 1'b0, s1_valid = 1'b0;
    logic [31:0]   s0_data = '0, s1_data = '0;
    logic          i2s_lrck = 1'b1, i2s_data_clk = 1'b0;

    logic          r0_z, r1_z, r0_h, r1_h;
    logic [W-1:0]  tx_z, tx_h;
    logic [1:0]    gr_z, gr_h;
    logic [15:0]   ur_z, ur_h;

    always #5 CLK = ~CLK;

    i2s_frame_sched #(.W(W), .SYNC_STAGES(S), .UNDERRUN_HOLD(0)) dut_z (
        .CLK(CLK), .RST_n(RST_n), .en(en), .mode(mode),
        .src0_valid(s0_valid), .src0_ready(r0_z), .src0_data(s0_data),
        .src1_valid(s1_valid), .src1_ready(r1_z), .src1_data(s1_data),
        .i2s_lrck(i2s_lrck), .i2s_data_clk(i2s_data_clk),
        .tx_data(tx_z), .grant(gr_z), .underrun_cnt(ur_z));

    i2s_frame_sched #(.W(W), .SYNC_STAGES(S), .UNDERRUN_HOLD(1)) dut_h (
        .CLK(CLK), .RST_n(RST_n), .en(en), .mode(mode),
        .src0_valid(s0_valid), .src0_ready(r0_h), .src0_data(s0_data),
        .src1_valid(s1_valid), .src1_ready(r1_h), .src1_data(s1_data),
        .i2s_lrck(i2s_lrck), .i2s_data_clk(i2s_data_clk),
        .tx_data(tx_h), .grant(gr_h), .underrun_cnt(ur_h));

    int          checks = 0;
    int          errors = 0;
    bit          m_full [2];
    logic [31:0] m_buf  [2];
    int          m_rr;
    int          m_ur;
    logic [31:0] m_last, m_act_z, m_act_h;
    logic [1:0]  m_grant;

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    task automatic model_reset();
        m_full[0] = 1'b0; m_full[1] = 1'b0;
        m_buf[0] = '0; m_buf[1] = '0;
        m_rr = 0; m_ur = 0;
        m_last = '0; m_act_z = '0; m_act_h = '0;
        m_grant = 2'b00;
    endtask

    task automatic hw_reset();
        RST_n = 1'b0; i2s_lrck = 1'b1; i2s_data_clk = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0;
        cyc(2);
        RST_n = 1'b1;
        cyc(2);
        model_reset();
    endtask

    // Present one frame on a source for a single cycle; it is taken only if the buffer is free.
    task automatic offer(input int s, input logic [31:0] d);
        logic exp_rdy;
        logic [1:0] got;
        exp_rdy = en & ~m_full[s];
        if (s == 0) begin s0_valid = 1'b1; s0_data = d; end
        else        begin s1_valid = 1'b1; s1_data = d; end
        #1;
        got = (s == 0) ? {r0_z, r0_h} : {r1_z, r1_h};
        checks++;
        if (got !== {2{exp_rdy}}) begin
            errors++;
            $display("FAIL ready src%0d: got %b expected %b", s, got, {2{exp_rdy}});
        end
        @(posedge CLK); #1;
        s0_valid = 1'b0; s1_valid = 1'b0;
        if (exp_rdy) begin m_full[s] = 1'b1; m_buf[s] = d; end
    endtask

    task automatic left_window(input string tag);
        int g;
        int md;
        logic [31:0] f;
        md = int'(mode);
        g = -1;
        f = '0;
        if (!en) begin
            m_act_z = '0; m_act_h = '0; m_grant = 2'b00;
        end else begin
            if (md == 2 && m_full[0] && m_full[1]) g = 2;
            else if (md == 1) begin
                if (m_full[m_rr]) g = m_rr;
                else if (m_full[1-m_rr]) g = 1 - m_rr;
                if (g >= 0) m_rr = 1 - g;
            end else begin
                if (m_full[0]) g = 0;
                else if (m_full[1]) g = 1;
            end
            if (g == 2) begin
                f = {sat16(m_buf[0][31:16], m_buf[1][31:16]), sat16(m_buf[0][15:0], m_buf[1][15:0])};
                m_full[0] = 1'b0; m_full[1] = 1'b0; m_grant = 2'b11;
            end else if (g >= 0) begin
                f = m_buf[g]; m_full[g] = 1'b0; m_grant = (g == 0) ? 2'b01 : 2'b10;
            end
            if (g >= 0) begin
                m_act_z = f; m_act_h = f; m_last = f;
            end else begin
                if (m_ur < 65535) m_ur++;
                m_grant = 2'b00; m_act_z = '0; m_act_h = m_last;
            end
        end
        i2s_lrck = 1'b1;
        cyc(3);
        i2s_data_clk = 1'b1;
        cyc(S + 3);
        checks++;
        if ({tx_z, tx_h} !== {m_act_z[31:16], m_act_h[31:16]}) begin
            errors++;
            $display("FAIL %s left tx: got %h/%h expected %h/%h", tag, tx_z, tx_h, m_act_z[31:16], m_act_h[31:16]);
        end
        checks++;
        if ({gr_z, gr_h} !== {m_grant, m_grant}) begin
            errors++;
            $display("FAIL %s grant: got %b/%b expected %b", tag, gr_z, gr_h, m_grant);
        end
        checks++;
        if (ur_z !== 16'(m_ur) || ur_h !== 16'(m_ur)) begin
            errors++;
            $display("FAIL %s underrun_cnt: got %0d/%0d expected %0d", tag, ur_z, ur_h, m_ur);
        end
        i2s_data_clk = 1'b0;
        cyc(3);
        i2s_lrck = 1'b0;
        cyc(4);
    endtask

    task automatic right_window(input string tag);
        if (!en) begin m_act_z = '0; m_act_h = '0; m_grant = 2'b00; end
        i2s_data_clk = 1'b1;
        cyc(S + 3);
        checks++;
        if ({tx_z, tx_h} !== {m_act_z[15:0], m_act_h[15:0]} || {gr_z, gr_h} !== {m_grant, m_grant}) begin
            errors++;
            $display("FAIL %s right tx/grant: got %h/%h %b/%b expected %h/%h %b", tag, tx_z, tx_h,
                     gr_z, gr_h, m_act_z[15:0], m_act_h[15:0], m_grant);
        end
        i2s_data_clk = 1'b0;
        cyc(3);
        i2s_lrck = 1'b1;
        cyc(4);
    endtask

    task automatic test_reset();
        en = 1'b1;
        RST_n = 1'b0;
        #1;
        checks++;
        if ({tx_z, tx_h, gr_z, gr_h, ur_z, ur_h, r0_z, r1_z, r0_h, r1_h} !== '0) begin
            errors++;
            $display("FAIL reset_values: got tx %h/%h grant %b/%b cnt %0d/%0d ready %b%b%b%b expected all 0",
                     tx_z, tx_h, gr_z, gr_h, ur_z, ur_h, r0_z, r1_z, r0_h, r1_h);
        end
        hw_reset();
    endtask

    task automatic test_basic();
        hw_reset();
        en = 1'b1; mode = '0;
        offer(0, 32'h1234_ABCD);
        left_window("basic");
        right_window("basic");
        offer(0, 32'h0BAD_F00D);
    endtask

    task automatic test_priority(input int md, input string tag);
        hw_reset();
        en = 1'b1; mode = MW'(md);
        for (int i = 0; i < 4; i++) begin
            offer(0, 32'h1111_2222);
            offer(1, 32'h3333_4444);
            left_window(tag);
            right_window(tag);
        end
    endtask

    task automatic test_underrun();
        hw_reset();
        en = 1'b1; mode = '0;
        offer(0, 32'h5555_6666);
        left_window("underrun_first");
        right_window("underrun_first");
        for (int i = 0; i < 3; i++) begin
            left_window("underrun");
            right_window("underrun");
        end
    endtask

    task automatic test_enable();
        hw_reset();
        en = 1'b1; mode = '0;
        offer(0, 32'hA0A1_A2A3);
        offer(1, 32'hB0B1_B2B3);
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            offer(0, 32'hDEAD_BEEF);
            left_window("disabled");
            right_window("disabled");
        end
        en = 1'b1;
        left_window("enable_resume");
        right_window("enable_resume");
        en = 1'b0;
        left_window("enable_mid");
        en = 1'b1;
        right_window("enable_mid");
    endtask

    task automatic test_reset_mid();
        hw_reset();
        en = 1'b1; mode = '0;
        offer(0, 32'h0101_0202);
        offer(1, 32'h0303_0404);
        left_window("pre_reset");
        right_window("pre_reset");
        offer(0, 32'h0505_0606);
        left_window("pre_reset2");
        RST_n = 1'b0; i2s_lrck = 1'b1;
        #1;
        checks++;
        if ({tx_z, tx_h, gr_z, ur_z} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got tx %h/%h grant %b cnt %0d expected 0", tx_z, tx_h, gr_z, ur_z);
        end
        cyc(2);
        RST_n = 1'b1;
        cyc(2);
        model_reset();
        left_window("post_reset_empty");
        right_window("post_reset_empty");
        offer(0, 32'h1234_ABCD);
        offer(1, 32'h4321_DCBA);
        left_window("post_reset");
        right_window("post_reset");
    endtask

    task automatic test_random(input int md, input int n, input string tag);
        hw_reset();
        mode = MW'(md);
        for (int i = 0; i < n; i++) begin
            en = ($urandom_range(0, 9) != 0);
            for (int s = 0; s < 2; s++)
                if ($urandom_range(0, 99) < 60) offer(s, $urandom);
            left_window(tag);
            if ($urandom_range(0, 9) == 0) en = ~en;
            right_window(tag);
        end
    endtask

`ifdef I2S_FRAME_SCHED_MIX_EN
    task automatic test_mix();
        hw_reset();
        en = 1'b1; mode = 2'd2;
        offer(0, 32'h7000_8000);
        offer(1, 32'h2000_8000);
        left_window("mix_sat");
        right_window("mix_sat");
        checks++;
        if (tx_z !== 16'h8000 || gr_z !== 2'b11) begin
            errors++;
            $display("FAIL mix_neg_clamp: got %h grant %b expected 8000 grant 11", tx_z, gr_z);
        end
        offer(1, 32'h0123_4567);
        left_window("mix_single");
        right_window("mix_single");
        test_random(2, 30, "rand_mix");
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_priority(0, "fixed_prio");
        test_priority(1, "round_robin");
        test_underrun();
        test_enable();
        test_reset_mid();
        test_random(0, 30, "rand_fixed");
        test_random(1, 30, "rand_rr");
`ifdef I2S_FRAME_SCHED_MIX_EN
        test_mix();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_frame_sched.md
Name: i2s_frame_sched

Overview:
- Feeds the 16-bit I2S transmitter's parallel sample input.
- Arbitrates between two stereo frame sources (e.g. PS audio stream and PL tone generator), each with a valid/ready handshake.
- Watches the transmitter's LCRK and DATA_CLK outputs to know when each sample is loaded, then presents the correct left/right word in time.
- Counts underruns when no frame is available at a frame boundary.

Parameters:
- W, 16, sample width in bits; must match the transmitter.
- SYNC_STAGES, 2, flip-flop stages used to synchronise LCRK and DATA_CLK into the CLK domain (valid range 2..3).
- UNDERRUN_HOLD, 0, 0 = output zeros on underrun; 1 = repeat the last frame.

Ports:
- CLK  in  1  system clock; same clock that drives the transmitter MCLK.
- RST_n  in  1  asynchronous active-low reset.
- en  in  1  scheduler enable.
- mode  in  1  arbitration mode: 0 = fixed priority to src0; 1 = round robin.
- src0_valid  in  1  src0 frame valid.
- src0_ready  out  1  src0 frame accepted when valid & ready.
- src0_data  in  2*W  src0 frame; [2W-1:W] = left, [W-1:0] = right.
- src1_valid  in  1  src1 frame valid.
- src1_ready  out  1  src1 frame accepted when valid & ready.
- src1_data  in  2*W  src1 frame; same packing as src0.
- i2s_lrck  in  1  LCRK from the transmitter.
- i2s_data_clk  in  1  DATA_CLK from the transmitter; high while the transmitter is ready to load.
- tx_data  out  W  sample driven to the transmitter's data_input.
- grant  out  2  one-hot owner of the current frame; 00 = none (underrun or disabled).
- underrun_cnt  out  16  saturating underrun counter.

Behaviour:
- Reset values: tx_data = 0, grant = 00, underrun_cnt = 0, src*_ready = 0, both frame buffers empty, round-robin pointer = src0, last frame = 0.
- Synchronisation: i2s_lrck and i2s_data_clk each pass through SYNC_STAGES flip-flops.
- Load window: starts when the synchronised DATA_CLK goes from 0 to 1, detected in one CLK cycle (win_start).
- Slot decode at win_start, from the synchronised lrck:
  - lrck = 1: the next slot is left (LCRK flips to 0), which is a frame boundary.
  - lrck = 0: the next slot is right.
- Input buffering: each source has a one-entry buffer.
  - srcN_ready = en & ~bufN_full.
  - A handshake (valid & ready) loads the buffer and sets full on the next CLK.
  - There is no same-cycle pop and refill.
- State machine (states WAIT_WIN, ARB, DRIVE_L, DRIVE_R):
  - WAIT_WIN: on win_start with a left slot, go to ARB; with a right slot, go to DRIVE_R.
  - ARB, grant selection:
    - mode 0: grant src0 if buf0 is full, else src1 if buf1 is full.
    - mode 1: grant the full buffer starting from the RR pointer; the pointer moves to the other source after each grant.
  - ARB, action:
    - The granted buffer is popped into the active frame register, which also becomes the last frame.
    - If no buffer is full, it is an underrun: underrun_cnt += 1 (saturating at 0xFFFF), grant = 00, and the active frame is {2W{0}} or the last frame, per UNDERRUN_HOLD.
    - Go to DRIVE_L.
  - DRIVE_L: tx_data <= active[2W-1:W]; go to WAIT_WIN.
  - DRIVE_R: tx_data <= active[W-1:0]; go to WAIT_WIN.
- Latency: tx_data is valid at most SYNC_STAGES+3 CLK after the DATA_CLK rise. This is well inside the 7-BSCK window (56 CLK at a divide-by-8 BSCK).
- tx_data holds its value between windows.
- en = 0:
  - ready drops, buffers are not popped, and full buffers are retained.
  - At every window tx_data <= 0 and grant = 00; no underrun is counted.
  - FSM stays in WAIT_WIN.
- en rising mid-frame: the first action is taken at the next left-slot window. A right-slot window before it drives 0.
- First window after reset is a left slot (LCRK resets to 1).
- Asynchronous reset mid-operation returns everything to the reset values immediately. Source data held in the buffers is discarded.

Optional Feature:
- Macro: I2S_FRAME_SCHED_MIX_EN.
- Defined:
  - mode is widened to 2 bits, and mode = 2 selects mix.
  - In mix, at ARB both full buffers are popped.
  - Left and right are each the signed saturating sum of both sources' words (clamped to 0x7FFF / 0x8000).
  - A single full source is passed through unchanged.
  - grant = 11 when both are mixed.
- Not defined: mode is 1 bit and mode = 2 does not exist.

Test Plan:
- Reset, en = 1, src0 presents 0x1234_ABCD -> first left window tx_data = 0x1234, then right window 0xABCD; grant = 01; src0_ready returns to 1 after the handshake.
- mode 0, both sources always valid (src0 = 0x1111_2222, src1 = 0x3333_4444) -> every frame is granted to src0; src1_ready stays 0 after the first accept.
- mode 1, same stimulus -> frames alternate 0x1111/0x2222, 0x3333/0x4444, …; grant toggles 01/10.
- No valid sources for 3 frames, UNDERRUN_HOLD = 0 -> tx_data = 0, underrun_cnt = 3, grant = 00; rerun with UNDERRUN_HOLD = 1 after one 0x5555_6666 frame -> that frame repeats and the counter increments the same way.
- en = 0 with both buffers full for 2 frames -> tx_data = 0, no pops, underrun_cnt unchanged; en = 1 -> the buffered src0 frame plays at the next left slot.
- RST_n asserted between the left and right windows -> tx_data = 0 immediately, buffers empty; after release the next left window behaves as the first frame. With MIX_EN: 0x7000 + 0x2000 -> 0x7FFF.
